alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequencer that shares the single registered 8-bit ALU between two requesters (e.g. the instruction datapath and a debug/maintenance port). It owns the ALU operand and control inputs, grants requesters round-robin, accounts for the ALU's one-cycle registered latency, and returns each result on a shared response channel with valid/ready backpressure. Illegal opcode 3'b011 is trapped without touching the ALU.

## Interface
Parameters:
- WIDTH, 8, operand/result width
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  requester has an operation
- req0_ready / req1_ready  out  1  requester's operation accepted this cycle
- req0_srca, req0_srcb / req1_srca, req1_srcb  in  WIDTH  operands
- req0_op / req1_op  in  3  ALU control code (000 AND, 001 OR, 010 ADD, 100 A&~B, 101 A|~B, 110 SUB, 111 SLT; 011 illegal)
- alu_srca, alu_srcb  out  WIDTH  ALU operands
- alu_control  out  3  ALU control
- alu_result  in  WIDTH  ALU registered output, valid the cycle after operands are driven
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester the response belongs to (0/1)
- rsp_data  out  WIDTH  result
- rsp_err  out  1  operation was illegal opcode
- busy  out  1  state != IDLE
- op_count  out  CNT_W  completed responses (legal and illegal), wraps

## Operation
- States: IDLE, EXEC, CAPT, RESP.
- IDLE: arbitrate. One valid -> grant it. Both valid -> grant requester named by priority pointer `prio`. Grant asserts that requester's reqN_ready combinationally (depends on both valids and prio); other ready = 0. No valid -> stay.
- On grant: latch srca, srcb, op, id; `prio` <= other requester. Legal op -> EXEC; op 3'b011 -> RESP with rsp_data = 0, rsp_err = 1.
- EXEC: alu_srca/srcb/control driven from latched values (held from latch until leaving CAPT). -> CAPT.
- CAPT: latch alu_result into rsp_data, rsp_err = 0. -> RESP.
- RESP: rsp_valid = 1; rsp_id/data/err stable. rsp_ready = 1 -> op_count += 1 (mod 2^CNT_W), -> IDLE. Else hold.
- Outside EXEC/CAPT, ALU inputs hold last latched values (no glitching required, but must be stable during EXEC).
- reqN_ready = 0 in every state except IDLE; requesters must hold valid and payload until ready.
- SLT result is whatever the ALU returns; arbiter does not interpret data.

## Timing
- Reset (async, rst_n low): state IDLE, prio = 0, req ready outputs 0 (no valid), rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0, alu_srca/srcb 0, alu_control 000, busy 0, op_count 0. Reset mid-operation discards the in-flight op; no response produced.
- Legal op: accept at cycle T (IDLE), EXEC T+1, CAPT T+2, rsp_valid from T+3. With rsp_ready held high, next accept possible at T+4: peak throughput 1 op / 4 cycles.
- Illegal op: accept at T, rsp_valid at T+1; next accept at T+2 earliest.
- prio updates only on a grant; a lone requester granted repeatedly still toggles prio.
- busy = 1 from T+1 until the cycle after the RESP handshake.
- op_count increments on the rsp_valid & rsp_ready edge; FFFF -> 0000.

## Test plan
- Single legal op: req0 ADD 8'h0F + 8'h01, rsp_ready=1 -> req0_ready at T, alu_control=010 at T+1, rsp_valid at T+3 with rsp_id=0, rsp_data=8'h10, rsp_err=0, op_count=1 after.
- Contention: both valid every cycle from reset -> grants alternate 0,1,0,1 (first to 0), rsp_id sequence matches, each 4 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_valid/data/id stable, both reqN_ready stay 0, single op_count increment on release.
- Illegal op: req1_op=3'b011 -> rsp_valid at T+1, rsp_err=1, rsp_data=0, rsp_id=1, alu_control unchanged.
- Reset mid-op: assert rst_n low during CAPT -> all outputs to reset values immediately; after release first grant goes to req0, no stale response.
- Counter wrap: force 65536 completions (or CNT_W=4, 16 ops) -> op_count returns to 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters share one registered ALU.
// Requesters are granted round-robin. The arbiter waits out the ALU's
// one-cycle latency and returns each result on a valid/ready response
// channel. Illegal opcode 3'b011 is answered with an error response and
// never reaches the ALU.
//
// state | meaning
// IDLE  | arbitrate between requesters, accept one operation
// EXEC  | ALU inputs driven from latched operands/opcode
// CAPT  | ALU output valid, captured into response register
// RESP  | response presented, waiting for rsp_ready
module alu_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_srca,
    input  logic [WIDTH-1:0] req0_srcb,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_srca,
    input  logic [WIDTH-1:0] req1_srcb,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] CAPT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [2:0]       OP_ILLEGAL = 3'b011;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic             prio;
    logic             grant0;
    logic             grant1;
    logic             grant_any;
    logic [WIDTH-1:0] sel_srca;
    logic [WIDTH-1:0] sel_srcb;
    logic [2:0]       sel_op;

    // Round-robin grant: a lone requester always wins, a tie goes to prio.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            grant0 = req0_valid && (!req1_valid || !prio);
            grant1 = req1_valid && (!req0_valid ||  prio);
        end
        grant_any = grant0 || grant1;
        sel_srca  = grant1 ? req1_srca : req0_srca;
        sel_srcb  = grant1 ? req1_srcb : req0_srcb;
        sel_op    = grant1 ? req1_op   : req0_op;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);

    // Sequencer: latch on grant, walk the ALU pipeline, hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prio        <= 1'b0;
            alu_srca    <= '0;
            alu_srcb    <= '0;
            alu_control <= 3'b000;
            rsp_id      <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            op_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        rsp_id <= grant1;
                        prio   <= !grant1;
                        if (sel_op == OP_ILLEGAL) begin
                            // Trapped: ALU inputs keep their previous values.
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                            state    <= RESP;
                        end else begin
                            alu_srca    <= sel_srca;
                            alu_srcb    <= sel_srcb;
                            alu_control <= sel_op;
                            state       <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    state <= CAPT;
                end
                CAPT: begin
                    rsp_data <= alu_result;
                    rsp_err  <= 1'b0;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + CNT_ONE;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small registered ALU model.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_alu_arbiter;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
    logic [2:0]       req0_op, req1_op;
    logic [WIDTH-1:0] alu_srca, alu_srcb, alu_result;
    logic [2:0]       alu_control;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [WIDTH-1:0] rsp_data;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_op(req1_op),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_control(alu_control),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Registered ALU model.
    always @(posedge clk) begin
        case (alu_control)
            3'b000:  alu_result <= alu_srca & alu_srcb;
            3'b001:  alu_result <= alu_srca | alu_srcb;
            3'b010:  alu_result <= alu_srca + alu_srcb;
            3'b100:  alu_result <= alu_srca & ~alu_srcb;
            3'b101:  alu_result <= alu_srca | ~alu_srcb;
            3'b110:  alu_result <= alu_srca - alu_srcb;
            3'b111:  alu_result <= {7'd0, $signed(alu_srca) < $signed(alu_srcb)};
            default: alu_result <= 8'hXX;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_srca = '0; req0_srcb = '0; req0_op = 3'b000;
        req1_valid = 1'b0; req1_srca = '0; req1_srcb = '0; req1_op = 3'b000;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_alu_control", 32'(alu_control), 0);
        chk("rst_alu_srca", 32'(alu_srca), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_op_count", 32'(op_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single legal op: 0F + 01 on requester 0
        req0_valid = 1'b1; req0_srca = 8'h0F; req0_srcb = 8'h01; req0_op = 3'b010;
        #1;
        chk("t1_req0_ready", 32'(req0_ready), 1);
        chk("t1_req1_ready", 32'(req1_ready), 0);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("t1_exec_busy", 32'(busy), 1);
        chk("t1_exec_ctrl", 32'(alu_control), 32'h2);
        chk("t1_exec_srca", 32'(alu_srca), 32'h0F);
        chk("t1_exec_ready", 32'(req0_ready), 0);
        @(negedge clk);
        chk("t1_capt_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsp_valid), 1);
        chk("t1_rsp_id", 32'(rsp_id), 0);
        chk("t1_rsp_data", 32'(rsp_data), 32'h10);
        chk("t1_rsp_err", 32'(rsp_err), 0);
        chk("t1_cnt_before", 32'(op_count), 0);
        @(negedge clk);
        chk("t1_done_valid", 32'(rsp_valid), 0);
        chk("t1_done_busy", 32'(busy), 0);
        chk("t1_cnt_after", 32'(op_count), 1);

        // Contention from reset: req0 ADD 1+2=3, req1 SUB 9-3=6
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_srca = 8'h01; req0_srcb = 8'h02; req0_op = 3'b010;
        req1_valid = 1'b1; req1_srca = 8'h09; req1_srcb = 8'h03; req1_op = 3'b110;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cont%0d_req0_ready", k), 32'(req0_ready), (k % 2 == 0) ? 1 : 0);
            chk($sformatf("cont%0d_req1_ready", k), 32'(req1_ready), (k % 2 == 1) ? 1 : 0);
            repeat (3) @(negedge clk);
            chk($sformatf("cont%0d_rsp_valid", k), 32'(rsp_valid), 1);
            chk($sformatf("cont%0d_rsp_id", k), 32'(rsp_id), (k % 2 == 1) ? 1 : 0);
            chk($sformatf("cont%0d_rsp_data", k), 32'(rsp_data), (k % 2 == 1) ? 32'h6 : 32'h3);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("cont_cnt", 32'(op_count), 4);

        // Backpressure: req1 AND F0 & 3C = 30, rsp_ready low for 5 cycles
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_srca = 8'hF0; req1_srcb = 8'h3C; req1_op = 3'b000;
        #1;
        chk("bp_req1_ready", 32'(req1_ready), 1);
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp%0d_rsp_valid", k), 32'(rsp_valid), 1);
            chk($sformatf("bp%0d_rsp_data", k), 32'(rsp_data), 32'h30);
            chk($sformatf("bp%0d_rsp_id", k), 32'(rsp_id), 1);
            chk($sformatf("bp%0d_readies", k), {30'd0, req1_ready, req0_ready}, 0);
            chk($sformatf("bp%0d_cnt", k), 32'(op_count), 4);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(rsp_valid), 0);
        chk("bp_release_cnt", 32'(op_count), 5);
        chk("bp_next_grant0", 32'(req0_ready), 1);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);

        // Illegal op on requester 1
        req1_valid = 1'b1; req1_srca = 8'h55; req1_srcb = 8'hAA; req1_op = 3'b011;
        #1;
        chk("ill_req1_ready", 32'(req1_ready), 1);
        @(negedge clk);
        req1_valid = 1'b0;
        chk("ill_rsp_valid", 32'(rsp_valid), 1);
        chk("ill_rsp_err", 32'(rsp_err), 1);
        chk("ill_rsp_data", 32'(rsp_data), 0);
        chk("ill_rsp_id", 32'(rsp_id), 1);
        chk("ill_alu_control", 32'(alu_control), 0);
        chk("ill_alu_srca", 32'(alu_srca), 32'hF0);
        @(negedge clk);
        chk("ill_done_busy", 32'(busy), 0);
        chk("ill_cnt", 32'(op_count), 6);

        // Reset during CAPT
        req0_valid = 1'b1; req0_srca = 8'h20; req0_srcb = 8'h22; req0_op = 3'b010;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ctrl", 32'(alu_control), 0);
        chk("mid_rst_srca", 32'(alu_srca), 0);
        chk("mid_rst_cnt", 32'(op_count), 0);
        chk("mid_rst_data", 32'(rsp_data), 0);
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'b000;
        req1_valid = 1'b1; req1_op = 3'b001;
        rst_n = 1'b1;
        #1;
        chk("post_rst_req0_ready", 32'(req0_ready), 1);
        chk("post_rst_req1_ready", 32'(req1_ready), 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_no_rsp", k), 32'(rsp_valid), 0);
        end

        // Counter wrap with CNT_W=4: 16 illegal ops from requester 0
        req0_valid = 1'b1; req0_op = 3'b011;
        repeat (31) @(negedge clk);
        chk("wrap_cnt15", 32'(op_count), 15);
        chk("wrap_last_rsp", 32'(rsp_valid), 1);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("wrap_cnt0", 32'(op_count), 0);
        chk("wrap_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
